axi_mem_arbiter: RTL and testbench
==================================

Name: axi_mem_arbiter

Overview:
- Shares the single AXI4-Lite memory port between two masters:
  - IFU: instruction fetch, read-only.
  - LSU: load/store, read and write.
- Sits between the two master interfaces and the SoC/memory slave.
- Grants one single-beat transaction at a time. The grant is held from address request until the R or B handshake completes.
- Ties are broken round-robin, so neither fetch nor load/store starves.

Parameters:
- ADDR_LEN, 32, address width of all AR/AW channels.
- DATA_LEN, 32, data width of R/W channels (WSTRB width = DATA_LEN/8).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- IFU read:
  - ifu_araddr in ADDR_LEN; ifu_arvalid in 1; ifu_arready out 1.
  - ifu_rdata out DATA_LEN; ifu_rresp out 2; ifu_rvalid out 1; ifu_rready in 1.
- LSU read:
  - lsu_araddr in ADDR_LEN; lsu_arsize in 3; lsu_arvalid in 1; lsu_arready out 1.
  - lsu_rdata out DATA_LEN; lsu_rresp out 2; lsu_rvalid out 1; lsu_rready in 1.
- LSU write:
  - lsu_awaddr in ADDR_LEN; lsu_awsize in 3; lsu_awvalid in 1; lsu_awready out 1.
  - lsu_wdata in DATA_LEN; lsu_wstrb in DATA_LEN/8; lsu_wvalid in 1; lsu_wready out 1.
  - lsu_bresp out 2; lsu_bvalid out 1; lsu_bready in 1.
- Slave side:
  - araddr, arsize, arvalid out; arready in.
  - rdata, rresp, rvalid in; rready out.
  - awaddr, awsize, awvalid out; awready in.
  - wdata, wstrb, wvalid out; wready in.
  - bresp, bvalid in; bready out.
  - Widths as on the master side.

Behaviour:
- Reset: state=IDLE, last_grant=IFU, aw_done=w_done=0.
  - All slave-side valid/ready outputs 0; all master-side ready/valid outputs 0.
  - Data/addr/resp outputs 0.
  - Reset mid-transaction abandons it; no response is forwarded afterwards.
- States (2-bit): IDLE=00, IFU_RD=01, LSU_RD=10, LSU_WR=11.
- IDLE arbitration (registered; grant visible the cycle after the request is sampled):
  - lsu_req = lsu_arvalid | (lsu_awvalid & lsu_wvalid).
  - If LSU and IFU both request, grant the one not equal to last_grant. Otherwise grant the sole requester.
  - An LSU grant with both lsu_awvalid&lsu_wvalid and lsu_arvalid goes to LSU_WR (write wins).
  - last_grant updates on each grant.
- IFU_RD:
  - Slave AR/R channels connect to the IFU: araddr=ifu_araddr, arsize=3'b010, arvalid=ifu_arvalid, ifu_arready=arready.
  - R channel forwarded both ways.
  - Exit to IDLE on rvalid&rready.
- LSU_RD: same as IFU_RD with the lsu_* signals (arsize=lsu_arsize). Exit on rvalid&rready.
- LSU_WR:
  - AW, W and B forwarded to the LSU.
  - aw_done is set on awvalid&awready; w_done on wvalid&wready.
  - Once a channel's done flag is set, the forwarded valid and the corresponding master ready are forced to 0, so there is no duplicate transfer when the slave accepts AW and W in different cycles.
  - Exit to IDLE on bvalid&bready; both flags clear at the same edge.
- Non-granted master: ready and valid outputs held 0. Unused slave channels: valid=0, ready=0.
- Master- and slave-side muxing is purely combinational from the state; zero added latency inside a granted transaction.
- Back-to-back: minimum one IDLE cycle between transactions; the next grant is decided in that IDLE cycle.
- RRESP/BRESP forwarded unmodified, including error codes. No retry is issued.
- Single-beat only; no ID or burst support.

Decomposition:
- Shared package/define file holds:
  - state encodings (ARB_IDLE, ARB_IFU_RD, ARB_LSU_RD, ARB_LSU_WR);
  - AXI resp codes (OKAY=2'b00, SLVERR=2'b10);
  - AXI size constant for a 4-byte access (3'b010).
- One sub-module is natural: axi_rr_grant, a 2-requester round-robin picker holding last_grant (inputs req[1:0], advance; output grant[1:0]).
- Channel muxes stay in the top module.

Test Plan:
- IFU alone: ifu_arvalid with addr 0x3000_0000; slave arready after 2 cycles and rdata 0xDEADBEEF -> ifu_arready pulses once, ifu_rdata=0xDEADBEEF, rresp=00, state returns to IDLE; LSU ready signals stay 0 throughout.
- Tie after reset: IFU and LSU reads asserted in the same cycle -> LSU granted first (last_grant=IFU). The next tie grants IFU; two further ties alternate LSU, IFU.
- LSU store with split acceptance: awready at cycle 1, wready at cycle 3, wstrb 4'b0011 -> slave sees exactly one AW and one W handshake. B forwarded with bresp 00; aw_done/w_done clear on B.
- Error passthrough: slave returns rresp 2'b10 on an LSU load -> lsu_rresp=2'b10, lsu_rvalid=1 for that beat, then IDLE.
- Reset asserted in LSU_RD before rvalid -> next cycle state=IDLE and all valid/ready outputs 0; a late slave rvalid is not forwarded to the LSU.
- Starvation check: IFU requests continuously while the LSU issues 10 loads -> grants alternate strictly and each master completes within 2 transactions of requesting.

Source files
------------

// File: rtl/axi_mem_arbiter_pkg.sv
// rtl/axi_mem_arbiter_pkg.sv - shared constants for the two-master AXI4-Lite memory arbiter
package axi_mem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    // Arbiter FSM encodings
    localparam arb_state_t ARB_IDLE   = 2'b00;
    localparam arb_state_t ARB_IFU_RD = 2'b01;
    localparam arb_state_t ARB_LSU_RD = 2'b10;
    localparam arb_state_t ARB_LSU_WR = 2'b11;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // AXI size code for a 4-byte access; instruction fetch is always a full word
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// rtl/axi_mem_arbiter_if.sv - single-beat AXI4-Lite bus bundle used on both sides of the arbiter
interface axi_mem_arbiter_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic [ADDR_LEN-1:0]   araddr;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_LEN-1:0]   rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_LEN-1:0]   awaddr;
    logic [2:0]            awsize;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_LEN-1:0]   wdata;
    logic [DATA_LEN/8-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arsize, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awsize, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arsize, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awsize, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_rr_grant.sv
// rtl/axi_rr_grant.sv - two-requester round-robin picker (bit 0 = IFU, bit 1 = LSU)
module axi_rr_grant (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last_lsu;

    // On a tie hand the grant to whoever did not win last time; otherwise pass the sole requester through.
    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = last_lsu ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner of every grant actually taken; reset favours the LSU on the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_lsu <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            last_lsu <= grant[1];
        end
    end
endmodule

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - shares one AXI4-Lite memory port between instruction fetch and load/store
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    axi_mem_arbiter_if.slave   ifu,
    axi_mem_arbiter_if.slave   lsu,
    axi_mem_arbiter_if.master  mem
);
    arb_state_t state;
    logic [1:0] req;
    logic [1:0] grant;
    logic       lsu_wr_req;
    logic       aw_done;
    logic       w_done;
    logic       r_done;
    logic       b_done;
    logic       unused_ifu_write;

    // The fetch master never writes; its write channels and size field are ignored.
    assign unused_ifu_write = ^{ifu.arsize, ifu.awaddr, ifu.awsize, ifu.awvalid,
                                ifu.wdata, ifu.wstrb, ifu.wvalid, ifu.bready};

    assign lsu_wr_req = lsu.awvalid & lsu.wvalid;
    assign req        = {lsu.arvalid | lsu_wr_req, ifu.arvalid};
    assign r_done     = mem.rvalid & mem.rready;
    assign b_done     = mem.bvalid & mem.bready;

    axi_rr_grant u_grant (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (state == ARB_IDLE),
        .grant   (grant)
    );

    // Grant from IDLE, hold until the response handshake of the granted transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant[1]) begin
                        state <= lsu_wr_req ? ARB_LSU_WR : ARB_LSU_RD;
                    end else if (grant[0]) begin
                        state <= ARB_IFU_RD;
                    end
                end
                ARB_IFU_RD, ARB_LSU_RD: begin
                    if (r_done) state <= ARB_IDLE;
                end
                default: begin
                    if (b_done) state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Track AW and W acceptance separately so a slave taking them in different cycles sees each once.
    always_ff @(posedge clock) begin
        if (reset || b_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == ARB_LSU_WR) begin
            if (mem.awvalid && mem.awready) aw_done <= 1'b1;
            if (mem.wvalid && mem.wready)   w_done  <= 1'b1;
        end
    end

    // Steer the granted master onto the slave port; everything else is held at zero.
    always_comb begin
        mem.araddr  = '0;
        mem.arsize  = '0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awaddr  = '0;
        mem.awsize  = '0;
        mem.awvalid = 1'b0;
        mem.wdata   = '0;
        mem.wstrb   = '0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;
        ifu.arready = 1'b0;
        ifu.rdata   = '0;
        ifu.rresp   = AXI_RESP_OKAY;
        ifu.rvalid  = 1'b0;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bresp   = AXI_RESP_OKAY;
        ifu.bvalid  = 1'b0;
        lsu.arready = 1'b0;
        lsu.rdata   = '0;
        lsu.rresp   = AXI_RESP_OKAY;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = AXI_RESP_OKAY;
        lsu.bvalid  = 1'b0;
        case (state)
            ARB_IFU_RD: begin
                mem.araddr  = ifu.araddr;
                mem.arsize  = AXI_SIZE_4B;
                mem.arvalid = ifu.arvalid;
                ifu.arready = mem.arready;
                ifu.rdata   = mem.rdata;
                ifu.rresp   = mem.rresp;
                ifu.rvalid  = mem.rvalid;
                mem.rready  = ifu.rready;
            end
            ARB_LSU_RD: begin
                mem.araddr  = lsu.araddr;
                mem.arsize  = lsu.arsize;
                mem.arvalid = lsu.arvalid;
                lsu.arready = mem.arready;
                lsu.rdata   = mem.rdata;
                lsu.rresp   = mem.rresp;
                lsu.rvalid  = mem.rvalid;
                mem.rready  = lsu.rready;
            end
            ARB_LSU_WR: begin
                mem.awaddr  = lsu.awaddr;
                mem.awsize  = lsu.awsize;
                mem.awvalid = lsu.awvalid & ~aw_done;
                lsu.awready = mem.awready & ~aw_done;
                mem.wdata   = lsu.wdata;
                mem.wstrb   = lsu.wstrb;
                mem.wvalid  = lsu.wvalid & ~w_done;
                lsu.wready  = mem.wready & ~w_done;
                lsu.bresp   = mem.bresp;
                lsu.bvalid  = mem.bvalid;
                mem.bready  = lsu.bready;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - self-checking bench for axi_mem_arbiter
module tb_axi_mem_arbiter;
    import axi_mem_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axi_mem_arbiter_if ifu_bus ();
    axi_mem_arbiter_if lsu_bus ();
    axi_mem_arbiter_if mem_bus ();

    axi_mem_arbiter dut (
        .clock (clock),
        .reset (reset),
        .ifu   (ifu_bus),
        .lsu   (lsu_bus),
        .mem   (mem_bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef enum {M_NONE, M_IFU_READ, M_LSU_READ, M_LSU_WRITE} owner_t;

    owner_t m_owner;
    owner_t grant_log[$];
    bit     m_aw_seen;
    bit     m_w_seen;

    int aw_hs, w_hs, ifu_ar_hs, lsu_activity;

    typedef struct {
        bit     ifu;
        bit     lsu_rd;
        bit     lsu_wr;
        owner_t exp;
    } arb_vec_t;

    arb_vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifu_bus.araddr = '0; ifu_bus.arsize = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 0;
        ifu_bus.awaddr = '0; ifu_bus.awsize = '0; ifu_bus.awvalid = 0;
        ifu_bus.wdata = '0; ifu_bus.wstrb = '0; ifu_bus.wvalid = 0; ifu_bus.bready = 0;
        lsu_bus.araddr = '0; lsu_bus.arsize = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 0;
        lsu_bus.awaddr = '0; lsu_bus.awsize = '0; lsu_bus.awvalid = 0;
        lsu_bus.wdata = '0; lsu_bus.wstrb = '0; lsu_bus.wvalid = 0; lsu_bus.bready = 0;
        mem_bus.arready = 0; mem_bus.rdata = '0; mem_bus.rresp = '0; mem_bus.rvalid = 0;
        mem_bus.awready = 0; mem_bus.wready = 0; mem_bus.bresp = '0; mem_bus.bvalid = 0;
    endtask

    // Expected outputs follow from who currently owns the port and which write halves were already sent.
    task automatic check_model();
        logic [110:0] e_mem, a_mem;
        logic [40:0]  e_ifu, a_ifu, e_lsu, a_lsu;
        e_mem = '0; e_ifu = '0; e_lsu = '0;
        case (m_owner)
            M_IFU_READ: begin
                e_mem = {ifu_bus.araddr, AXI_SIZE_4B, ifu_bus.arvalid, ifu_bus.rready,
                         32'h0, 3'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0};
                e_ifu = {mem_bus.arready, mem_bus.rdata, mem_bus.rresp, mem_bus.rvalid, 5'b0};
            end
            M_LSU_READ: begin
                e_mem = {lsu_bus.araddr, lsu_bus.arsize, lsu_bus.arvalid, lsu_bus.rready,
                         32'h0, 3'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0};
                e_lsu = {mem_bus.arready, mem_bus.rdata, mem_bus.rresp, mem_bus.rvalid, 5'b0};
            end
            M_LSU_WRITE: begin
                e_mem = {32'h0, 3'h0, 1'b0, 1'b0, lsu_bus.awaddr, lsu_bus.awsize,
                         lsu_bus.awvalid & !m_aw_seen, lsu_bus.wdata, lsu_bus.wstrb,
                         lsu_bus.wvalid & !m_w_seen, lsu_bus.bready};
                e_lsu = {1'b0, 32'h0, 2'b0, 1'b0, mem_bus.awready & !m_aw_seen,
                         mem_bus.wready & !m_w_seen, mem_bus.bresp, mem_bus.bvalid};
            end
            default: ;
        endcase
        a_mem = {mem_bus.araddr, mem_bus.arsize, mem_bus.arvalid, mem_bus.rready, mem_bus.awaddr,
                 mem_bus.awsize, mem_bus.awvalid, mem_bus.wdata, mem_bus.wstrb, mem_bus.wvalid, mem_bus.bready};
        a_ifu = {ifu_bus.arready, ifu_bus.rdata, ifu_bus.rresp, ifu_bus.rvalid,
                 ifu_bus.awready, ifu_bus.wready, ifu_bus.bresp, ifu_bus.bvalid};
        a_lsu = {lsu_bus.arready, lsu_bus.rdata, lsu_bus.rresp, lsu_bus.rvalid,
                 lsu_bus.awready, lsu_bus.wready, lsu_bus.bresp, lsu_bus.bvalid};
        check("model_slave_side", 128'(a_mem), 128'(e_mem));
        check("model_ifu_side", 128'(a_ifu), 128'(e_ifu));
        check("model_lsu_side", 128'(a_lsu), 128'(e_lsu));
    endtask

    // Transaction-level view: who gets the port next, and when the current owner is finished.
    task automatic model_advance();
        bit want_i, want_l, pick_l;
        if (reset) begin
            m_owner = M_NONE;
            grant_log.delete();
            m_aw_seen = 0;
            m_w_seen = 0;
        end else begin
            case (m_owner)
                M_NONE: begin
                    want_i = ifu_bus.arvalid;
                    want_l = lsu_bus.arvalid | (lsu_bus.awvalid & lsu_bus.wvalid);
                    if (want_i && want_l)
                        pick_l = (grant_log.size() == 0) || (grant_log[$] == M_IFU_READ);
                    else
                        pick_l = want_l;
                    if (pick_l)
                        m_owner = (lsu_bus.awvalid && lsu_bus.wvalid) ? M_LSU_WRITE : M_LSU_READ;
                    else if (want_i)
                        m_owner = M_IFU_READ;
                    if (m_owner != M_NONE) grant_log.push_back(m_owner);
                end
                M_IFU_READ: if (mem_bus.rvalid && ifu_bus.rready) m_owner = M_NONE;
                M_LSU_READ: if (mem_bus.rvalid && lsu_bus.rready) m_owner = M_NONE;
                M_LSU_WRITE: begin
                    if (mem_bus.bvalid && lsu_bus.bready) begin
                        m_owner = M_NONE;
                        m_aw_seen = 0;
                        m_w_seen = 0;
                    end else begin
                        if (lsu_bus.awvalid && mem_bus.awready) m_aw_seen = 1;
                        if (lsu_bus.wvalid && mem_bus.wready) m_w_seen = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        #1;
        check_model();
        if (mem_bus.awvalid && mem_bus.awready) aw_hs++;
        if (mem_bus.wvalid && mem_bus.wready) w_hs++;
        if (ifu_bus.arvalid && ifu_bus.arready) ifu_ar_hs++;
        if (lsu_bus.arready || lsu_bus.awready || lsu_bus.wready || lsu_bus.rvalid || lsu_bus.bvalid)
            lsu_activity++;
        model_advance();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int lsu_done, ifu_done, txn, who;
        logic [2:0] exp_bits;

        vecs[0] = '{1'b1, 1'b1, 1'b0, M_LSU_READ};
        vecs[1] = '{1'b1, 1'b1, 1'b0, M_IFU_READ};
        vecs[2] = '{1'b1, 1'b1, 1'b0, M_LSU_READ};
        vecs[3] = '{1'b1, 1'b1, 1'b0, M_IFU_READ};
        vecs[4] = '{1'b1, 1'b0, 1'b0, M_IFU_READ};
        vecs[5] = '{1'b1, 1'b0, 1'b1, M_LSU_WRITE};
        vecs[6] = '{1'b0, 1'b1, 1'b1, M_LSU_WRITE};
        vecs[7] = '{1'b1, 1'b1, 1'b1, M_IFU_READ};
        vecs[8] = '{1'b0, 1'b1, 1'b0, M_LSU_READ};
        vecs[9] = '{1'b1, 1'b0, 1'b1, M_IFU_READ};

        clear_inputs();
        reset = 1;
        m_owner = M_NONE;
        m_aw_seen = 0;
        m_w_seen = 0;
        aw_hs = 0; w_hs = 0; ifu_ar_hs = 0; lsu_activity = 0;
        @(posedge clock);
        #1;
        // Under reset every handshake output stays low even with all inputs active.
        ifu_bus.arvalid = 1; lsu_bus.arvalid = 1; lsu_bus.awvalid = 1; lsu_bus.wvalid = 1;
        mem_bus.arready = 1; mem_bus.rvalid = 1; mem_bus.awready = 1; mem_bus.wready = 1; mem_bus.bvalid = 1;
        #1;
        check("reset_handshakes",
              128'({mem_bus.arvalid, mem_bus.rready, mem_bus.awvalid, mem_bus.wvalid, mem_bus.bready,
                    ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.rvalid,
                    lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid}), 128'(0));
        step();
        reset = 0;
        clear_inputs();

        // Arbitration table, starting from last_grant = IFU
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            ifu_bus.araddr = $urandom; lsu_bus.araddr = $urandom; lsu_bus.awaddr = $urandom;
            ifu_bus.arvalid = vecs[i].ifu;
            lsu_bus.arvalid = vecs[i].lsu_rd;
            lsu_bus.awvalid = vecs[i].lsu_wr;
            lsu_bus.wvalid  = vecs[i].lsu_wr;
            ifu_bus.rready = 1; lsu_bus.rready = 1; lsu_bus.bready = 1;
            step();
            mem_bus.arready = 1; mem_bus.awready = 1; mem_bus.wready = 1;
            mem_bus.rvalid = 1; mem_bus.bvalid = 1;
            #1;
            case (vecs[i].exp)
                M_IFU_READ: exp_bits = 3'b100;
                M_LSU_READ: exp_bits = 3'b010;
                default:    exp_bits = 3'b001;
            endcase
            check($sformatf("table_grant[%0d]", i),
                  128'({ifu_bus.arready, lsu_bus.arready, lsu_bus.awready}), 128'(exp_bits));
            step();
        end

        // IFU alone, slave accepts after two cycles
        clear_inputs();
        ifu_ar_hs = 0; lsu_activity = 0;
        ifu_bus.araddr = 32'h3000_0000; ifu_bus.arvalid = 1; ifu_bus.rready = 1;
        step();
        check("ifu_araddr_fwd", 128'({mem_bus.araddr, mem_bus.arsize, mem_bus.arvalid}),
              128'({32'h3000_0000, 3'b010, 1'b1}));
        step();
        step();
        mem_bus.arready = 1;
        step();
        ifu_bus.arvalid = 0; mem_bus.arready = 0;
        mem_bus.rvalid = 1; mem_bus.rdata = 32'hDEAD_BEEF; mem_bus.rresp = AXI_RESP_OKAY;
        #1;
        check("ifu_rdata", 128'({ifu_bus.rvalid, ifu_bus.rdata, ifu_bus.rresp}),
              128'({1'b1, 32'hDEAD_BEEF, 2'b00}));
        step();
        mem_bus.rvalid = 0;
        check("ifu_ar_pulses", 128'(ifu_ar_hs), 128'(1));
        check("lsu_quiet", 128'(lsu_activity), 128'(0));
        ifu_bus.arvalid = 1; mem_bus.arready = 1;
        #1;
        check("idle_no_fwd", 128'({mem_bus.arvalid, ifu_bus.arready}), 128'(0));
        step();
        mem_bus.rvalid = 1;
        step();

        // LSU store, AW and W accepted in different cycles
        clear_inputs();
        aw_hs = 0; w_hs = 0;
        lsu_bus.awaddr = 32'h8000_0010; lsu_bus.awsize = 3'b001; lsu_bus.awvalid = 1;
        lsu_bus.wdata = 32'h1234_ABCD; lsu_bus.wstrb = 4'b0011; lsu_bus.wvalid = 1; lsu_bus.bready = 1;
        step();
        mem_bus.awready = 1;
        step();
        step();
        mem_bus.wready = 1;
        #1;
        check("wstrb_fwd", 128'({mem_bus.wdata, mem_bus.wstrb}), 128'({32'h1234_ABCD, 4'b0011}));
        step();
        mem_bus.bvalid = 1; mem_bus.bresp = AXI_RESP_OKAY;
        #1;
        check("b_fwd", 128'({lsu_bus.bvalid, lsu_bus.bresp}), 128'(3'b100));
        check("aw_w_suppressed", 128'({mem_bus.awvalid, mem_bus.wvalid}), 128'(0));
        step();
        mem_bus.bvalid = 0; mem_bus.awready = 0; mem_bus.wready = 0;
        check("aw_handshakes", 128'(aw_hs), 128'(1));
        check("w_handshakes", 128'(w_hs), 128'(1));
        step();
        check("flags_cleared", 128'({mem_bus.awvalid, mem_bus.wvalid}), 128'(2'b11));
        mem_bus.awready = 1; mem_bus.wready = 1; mem_bus.bvalid = 1;
        step();

        // Error response on an LSU load passes through untouched
        clear_inputs();
        lsu_bus.araddr = 32'h0000_0104; lsu_bus.arsize = 3'b000; lsu_bus.arvalid = 1; lsu_bus.rready = 1;
        step();
        mem_bus.arready = 1;
        step();
        lsu_bus.arvalid = 0; mem_bus.arready = 0;
        mem_bus.rvalid = 1; mem_bus.rresp = AXI_RESP_SLVERR; mem_bus.rdata = $urandom;
        #1;
        check("lsu_rresp_err", 128'({lsu_bus.rvalid, lsu_bus.rresp, ifu_bus.rvalid}),
              128'({1'b1, AXI_RESP_SLVERR, 1'b0}));
        step();
        check("err_then_idle", 128'({lsu_bus.rvalid, mem_bus.rready}), 128'(0));
        step();

        // Reset while the LSU waits for its read data
        clear_inputs();
        lsu_bus.araddr = 32'h0000_0200; lsu_bus.arvalid = 1; lsu_bus.rready = 1;
        step();
        mem_bus.arready = 1;
        step();
        lsu_bus.arvalid = 0; mem_bus.arready = 0;
        reset = 1;
        step();
        reset = 0;
        mem_bus.rvalid = 1; mem_bus.rdata = 32'hCAFE_F00D; mem_bus.arready = 1;
        mem_bus.awready = 1; mem_bus.wready = 1; mem_bus.bvalid = 1;
        #1;
        check("post_reset_slave",
              128'({mem_bus.arvalid, mem_bus.rready, mem_bus.awvalid, mem_bus.wvalid, mem_bus.bready, mem_bus.araddr}),
              128'(0));
        check("post_reset_lsu",
              128'({lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid, lsu_bus.rdata}),
              128'(0));
        step();

        // Starvation: IFU always requesting, LSU issues ten loads; last_grant is IFU after the reset above
        clear_inputs();
        ifu_bus.arvalid = 1; ifu_bus.rready = 1; ifu_bus.araddr = 32'h0000_1000;
        lsu_bus.arvalid = 1; lsu_bus.rready = 1; lsu_bus.araddr = 32'h0000_2000;
        mem_bus.arready = 1; mem_bus.rvalid = 1; mem_bus.rdata = 32'h0BAD_F00D;
        lsu_done = 0; ifu_done = 0; txn = 0;
        while (lsu_done < 10 && txn < 40) begin
            if (lsu_done == 9 && (txn % 2) == 1) lsu_bus.arvalid = 1;
            step();
            who = lsu_bus.arready ? 1 : (ifu_bus.arready ? 0 : 2);
            check($sformatf("alternate[%0d]", txn), 128'(who), 128'((txn % 2 == 0) ? 1 : 0));
            if (who == 1) lsu_done++;
            else if (who == 0) ifu_done++;
            step();
            txn++;
        end
        check("starve_txns", 128'({txn, ifu_done}), 128'({32'd19, 32'd9}));

        // Randomised traffic against the transaction-level model
        for (int c = 0; c < 2000; c++) begin
            ifu_bus.araddr = $urandom; ifu_bus.arsize = 3'($urandom); ifu_bus.arvalid = 1'($urandom);
            ifu_bus.rready = 1'($urandom); ifu_bus.awaddr = $urandom; ifu_bus.awsize = 3'($urandom);
            ifu_bus.awvalid = 1'($urandom); ifu_bus.wdata = $urandom; ifu_bus.wstrb = 4'($urandom);
            ifu_bus.wvalid = 1'($urandom); ifu_bus.bready = 1'($urandom);
            lsu_bus.araddr = $urandom; lsu_bus.arsize = 3'($urandom); lsu_bus.arvalid = 1'($urandom);
            lsu_bus.rready = 1'($urandom); lsu_bus.awaddr = $urandom; lsu_bus.awsize = 3'($urandom);
            lsu_bus.awvalid = 1'($urandom); lsu_bus.wdata = $urandom; lsu_bus.wstrb = 4'($urandom);
            lsu_bus.wvalid = 1'($urandom); lsu_bus.bready = 1'($urandom);
            mem_bus.arready = 1'($urandom); mem_bus.rdata = $urandom; mem_bus.rresp = 2'($urandom);
            mem_bus.rvalid = 1'($urandom); mem_bus.awready = 1'($urandom); mem_bus.wready = 1'($urandom);
            mem_bus.bresp = 2'($urandom); mem_bus.bvalid = 1'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 0;
        clear_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
